// File: rtl/demux1t8_16_buf.sv
// demux1t8_16_buf
// Buffered 1-to-8 demultiplexer for W-bit words. A word offered on the
// valid/ready input is steered by in_sel into one of eight single-entry lane
// registers. Each lane hands its word to its own consumer through a
// valid/ready handshake, so a stalled lane never blocks the other lanes.
//
// Ports
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   in_data    word to distribute
//   in_sel     destination lane 0..7
//   in_valid   producer offers a word
//   in_ready   addressed lane can take the word this cycle
//   out_data   lane k word at [k*W +: W]
//   out_valid  bit k: lane k holds an undelivered word
//   out_ready  bit k: consumer k takes lane k's word this cycle
//   accept_cnt words accepted since reset, wraps
module demux1t8_16_buf #(
  parameter int W     = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [W-1:0]     in_data,
  input  logic [2:0]       in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [8*W-1:0]   out_data,
  output logic [7:0]       out_valid,
  input  logic [7:0]       out_ready,
  output logic [CNT_W-1:0] accept_cnt
);

  logic [W-1:0]     lane_data [8];
  logic [7:0]       full;
  logic [7:0]       en;
  logic [7:0]       drn;
  logic             acc;
  logic [CNT_W-1:0] cnt;

  assign en = 8'b1 << in_sel;

  // Only the addressed lane matters; a lane that is draining this cycle can
  // be refilled in the same cycle for back-to-back throughput.
  assign in_ready = ~rst & (~full[in_sel] | out_ready[in_sel]);
  assign acc      = in_valid & in_ready;
  assign drn      = full & out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      full <= 8'h00;
      cnt  <= '0;
      for (int k = 0; k < 8; k++) begin
        lane_data[k] <= '0;
      end
    end else begin
      for (int k = 0; k < 8; k++) begin
        if (acc && en[k]) begin
          lane_data[k] <= in_data;
          full[k]      <= 1'b1;
        end else if (drn[k]) begin
          // data is kept after delivery; only the full flag drops
          full[k] <= 1'b0;
        end
      end
      if (acc) begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  for (genvar k = 0; k < 8; k++) begin : g_lane
    assign out_data[k*W +: W] = lane_data[k];
  end

  assign out_valid  = full;
  assign accept_cnt = cnt;

endmodule
